// File: rtl/ste_shift_engine.sv
// ste_shift_engine: framed full-duplex shift engine.
// Each enabled beat moves LANES bits out of the transmit word and LANES bits in.
// The frame length (in beats) and the bit order are taken at load time.
// Valid/ready handshakes are used on the parallel load side and on the receive side.
// Optional build macro STE_SHIFT_ENGINE_PARITY_EN: when defined, rx_parity_o is the
// XOR of the received word. When it is not defined, the port is tied to 0.
module ste_shift_engine #(
    parameter  int SHIFT_W = 16,
    parameter  int LANES   = 1,
    localparam int BEAT_W  = $clog2(SHIFT_W / LANES) + 1
) (
    input  logic               clk,
    input  logic               reset_ni,
    input  logic               clr_i,
    input  logic               cfg_msb_first_i,
    input  logic [BEAT_W-1:0]  cfg_beats_i,
    input  logic               ld_valid_i,
    input  logic [SHIFT_W-1:0] ld_data_i,
    output logic               ld_ready_o,
    input  logic               shift_en_i,
    input  logic [LANES-1:0]   din_i,
    output logic [LANES-1:0]   dout_o,
    output logic               busy_o,
    output logic               rx_valid_o,
    input  logic               rx_ready_i,
    output logic [SHIFT_W-1:0] rx_data_o,
    output logic               rx_parity_o
);

    localparam logic [BEAT_W-1:0] MAX_BEATS = BEAT_W'(SHIFT_W / LANES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t             state_ff;
    logic [SHIFT_W-1:0] shift_ff;
    logic [SHIFT_W-1:0] shift_nxt;
    logic [BEAT_W-1:0]  cnt_ff;
    logic [BEAT_W-1:0]  eff_beats;
    logic               msb_first_ff;
    logic               last_beat;

    // Clamp the requested frame length: 0 or an oversize value means a full word
    always_comb begin
        // NOTE: give every always_comb output a default first, so that no path leaves it unassigned and infers a latch.
        eff_beats = cfg_beats_i;
        if ((cfg_beats_i == '0) || (cfg_beats_i > MAX_BEATS)) begin
            eff_beats = MAX_BEATS;
        end
    end

    // Next shift-register value for one beat, in the bit order latched at load
    always_comb begin
        shift_nxt = shift_ff;
        if (msb_first_ff) begin
            shift_nxt = {shift_ff[SHIFT_W-LANES-1:0], din_i};
        end else begin
            shift_nxt = {din_i, shift_ff[SHIFT_W-1:LANES]};
        end
    end

    assign last_beat = (state_ff == SHIFT) && shift_en_i && (cnt_ff == '0);

    // Frame sequencer: load in IDLE, shift on enabled beats, hold the word until it is consumed
    always_ff @(posedge clk or negedge reset_ni) begin
        // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
        if (!reset_ni) begin
            state_ff     <= IDLE;
            shift_ff     <= '0;
            cnt_ff       <= '0;
            msb_first_ff <= 1'b1;
        end else if (clr_i) begin
            state_ff <= IDLE;
            shift_ff <= '0;
            cnt_ff   <= '0;
        end else begin
            unique case (state_ff)
                IDLE: begin
                    if (ld_valid_i) begin
                        shift_ff     <= ld_data_i;
                        msb_first_ff <= cfg_msb_first_i;
                        cnt_ff       <= eff_beats - BEAT_W'(1);
                        state_ff     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (shift_en_i) begin
                        shift_ff <= shift_nxt;
                        if (cnt_ff == '0) begin
                            state_ff <= HOLD;
                        end else begin
                            cnt_ff <= cnt_ff - BEAT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (rx_ready_i) begin
                        state_ff <= IDLE;
                    end
                end
                default: state_ff <= IDLE;
            endcase
        end
    end

    // Current output lane: a direct slice of the register, so it stays still while shift_en_i is low
    always_comb begin
        dout_o = '0;
        if (state_ff == SHIFT) begin
            dout_o = msb_first_ff ? shift_ff[SHIFT_W-1 -: LANES] : shift_ff[LANES-1:0];
        end
    end

    assign ld_ready_o = (state_ff == IDLE);
    assign busy_o     = (state_ff == SHIFT);
    assign rx_valid_o = (state_ff == HOLD);
    assign rx_data_o  = (state_ff == HOLD) ? shift_ff : '0;

`ifdef STE_SHIFT_ENGINE_PARITY_EN
    logic parity_ff;

    // Capture the parity of the completed word on its final beat
    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            parity_ff <= 1'b0;
        end else if (clr_i) begin
            parity_ff <= 1'b0;
        end else if (last_beat) begin
            parity_ff <= ^shift_nxt;
        end
    end

    assign rx_parity_o = rx_valid_o & parity_ff;
`else
    assign rx_parity_o = 1'b0;
`endif

endmodule

// File: tb/tb_ste_shift_engine.sv
// tb_ste_shift_engine: directed scoreboard bench for ste_shift_engine.
// Instance a uses 16 bits with 1 lane, and instance b uses 16 bits with 4 lanes.
// Every expected receive word goes into a queue when its frame is loaded.
// A monitor per instance pops and compares on each receive handshake.
`timescale 1ns/1ps
module tb_ste_shift_engine;

`ifdef STE_SHIFT_ENGINE_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] data;
        logic        parity;
    } rx_exp_t;

    logic clk      = 1'b0;
    logic reset_ni = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    rx_exp_t q_a[$];
    rx_exp_t q_b[$];

    // Instance a: 1 lane, optional loopback from dout to din
    logic        a_clr = 0, a_msb = 1, a_ld_valid = 0, a_shift_en = 0, a_rx_ready = 1;
    logic        a_loop = 0, a_din_drv = 0;
    logic [4:0]  a_beats = 5'd16;
    logic [15:0] a_ld_data = '0;
    logic        a_din, a_dout, a_ld_ready, a_busy, a_rx_valid, a_rx_parity;
    logic [15:0] a_rx_data;
    assign a_din = a_loop ? a_dout : a_din_drv;

    // Instance b: 4 lanes
    logic        b_clr = 0, b_msb = 1, b_ld_valid = 0, b_shift_en = 0, b_rx_ready = 1;
    logic [2:0]  b_beats = 3'd0;
    logic [15:0] b_ld_data = '0;
    logic [3:0]  b_din = '0, b_dout;
    logic        b_ld_ready, b_busy, b_rx_valid, b_rx_parity;
    logic [15:0] b_rx_data;

    ste_shift_engine #(.SHIFT_W(16), .LANES(1)) u_a (
        .clk(clk), .reset_ni(reset_ni), .clr_i(a_clr),
        .cfg_msb_first_i(a_msb), .cfg_beats_i(a_beats),
        .ld_valid_i(a_ld_valid), .ld_data_i(a_ld_data), .ld_ready_o(a_ld_ready),
        .shift_en_i(a_shift_en), .din_i(a_din), .dout_o(a_dout), .busy_o(a_busy),
        .rx_valid_o(a_rx_valid), .rx_ready_i(a_rx_ready), .rx_data_o(a_rx_data),
        .rx_parity_o(a_rx_parity)
    );

    ste_shift_engine #(.SHIFT_W(16), .LANES(4)) u_b (
        .clk(clk), .reset_ni(reset_ni), .clr_i(b_clr),
        .cfg_msb_first_i(b_msb), .cfg_beats_i(b_beats),
        .ld_valid_i(b_ld_valid), .ld_data_i(b_ld_data), .ld_ready_o(b_ld_ready),
        .shift_en_i(b_shift_en), .din_i(b_din), .dout_o(b_dout), .busy_o(b_busy),
        .rx_valid_o(b_rx_valid), .rx_ready_i(b_rx_ready), .rx_data_o(b_rx_data),
        .rx_parity_o(b_rx_parity)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // par is the hand-computed parity of d; it is only expected when the feature is built in
    function automatic rx_exp_t mk(input logic [15:0] d, input logic par);
        rx_exp_t e;
        e.data   = d;
        e.parity = PAR_EN & par;
        return e;
    endfunction

    // Move to just after the next rising edge; outputs are checked and inputs driven here
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Monitors: compare on every receive handshake, sampled on the falling edge
    always @(negedge clk) begin
        rx_exp_t e;
        if (reset_ni && a_rx_valid && a_rx_ready) begin
            if (q_a.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL a_rx_unexpected: got 0x%0h, expected no word", a_rx_data);
            end else begin
                e = q_a.pop_front();
                check("a_rx_data", {16'h0, a_rx_data}, {16'h0, e.data});
                check("a_rx_parity", {31'h0, a_rx_parity}, {31'h0, e.parity});
            end
        end
    end

    always @(negedge clk) begin
        rx_exp_t e;
        if (reset_ni && b_rx_valid && b_rx_ready) begin
            if (q_b.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL b_rx_unexpected: got 0x%0h, expected no word", b_rx_data);
            end else begin
                e = q_b.pop_front();
                check("b_rx_data", {16'h0, b_rx_data}, {16'h0, e.data});
                check("b_rx_parity", {31'h0, b_rx_parity}, {31'h0, e.parity});
            end
        end
    end

    // Full 16-beat MSB-first loopback frame on instance a, with a bounded wait for completion
    task automatic frame_a(input logic [15:0] d, input logic par, input string name);
        int n;
        a_loop = 1; a_msb = 1; a_beats = 5'd16; a_ld_data = d;
        a_ld_valid = 1; a_shift_en = 1; a_rx_ready = 1;
        q_a.push_back(mk(d, par));
        cyc();
        a_ld_valid = 0;
        n = 0;
        while (!a_rx_valid && n < 64) begin
            cyc();
            n++;
        end
        check({name, "_done"}, {31'h0, a_rx_valid}, 32'd1);
        check({name, "_par"}, {31'h0, a_rx_parity}, {31'h0, PAR_EN & par});
        cyc();
        check({name, "_idle"}, {31'h0, a_ld_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [15:0] w;
        logic [7:0]  lsb_seq;
        logic [15:0] b_out_exp;
        logic [15:0] b_in_vec;

        // Reset values
        #12;
        check("rst_ld_ready", {31'h0, a_ld_ready}, 32'd1);
        check("rst_busy", {31'h0, a_busy}, 32'd0);
        check("rst_rx_valid", {31'h0, a_rx_valid}, 32'd0);
        check("rst_rx_data", {16'h0, a_rx_data}, 32'h0);
        check("rst_dout", {31'h0, a_dout}, 32'd0);
        check("rst_parity", {31'h0, a_rx_parity}, 32'd0);
        check("rst_b_ld_ready", {31'h0, b_ld_ready}, 32'd1);
        @(negedge clk);
        reset_ni = 1;
        cyc();

        // 1) MSB-first loopback of 0xA5C3: busy for 16 cycles, word returns intact
        a_loop = 1; a_msb = 1; a_beats = 5'd16; a_ld_data = 16'hA5C3;
        a_ld_valid = 1; a_shift_en = 1; a_rx_ready = 1;
        q_a.push_back(mk(16'hA5C3, 1'b0));
        cyc();
        a_ld_valid = 0;
        check("lb_first_dout", {31'h0, a_dout}, 32'd1);
        check("lb_ld_ready", {31'h0, a_ld_ready}, 32'd0);
        n = 0;
        while (a_busy && n < 40) begin
            n++;
            cyc();
        end
        check("lb_busy_cycles", n, 32'd16);
        check("lb_rx_valid", {31'h0, a_rx_valid}, 32'd1);
        cyc();
        check("lb_rx_data_cleared", {16'h0, a_rx_data}, 32'h0);
        check("lb_back_idle", {31'h0, a_ld_ready}, 32'd1);

        // 2) LSB-first 8-beat frame of 0x00F0 with din held 1 -> 0xFF00
        a_loop = 0; a_din_drv = 1; a_msb = 0; a_beats = 5'd8; a_ld_data = 16'h00F0;
        a_ld_valid = 1;
        q_a.push_back(mk(16'hFF00, 1'b0));
        lsb_seq = 8'b1111_0000;
        cyc();
        a_ld_valid = 0;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("lsb_dout%0d", i), {31'h0, a_dout}, {31'h0, lsb_seq[i]});
            cyc();
        end
        check("lsb_rx_valid", {31'h0, a_rx_valid}, 32'd1);
        cyc();

        // 3) Four lanes, beats=0 selects the full word: out 1,2,3,4 and in F,E,D,C
        b_msb = 1; b_beats = 3'd0; b_ld_data = 16'h1234; b_ld_valid = 1; b_shift_en = 1;
        q_b.push_back(mk(16'hFEDC, 1'b0));
        b_out_exp = 16'h1234;
        b_in_vec  = 16'hFEDC;
        cyc();
        b_ld_valid = 0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("quad_dout%0d", i), {28'h0, b_dout}, {28'h0, b_out_exp[15-4*i -: 4]});
            b_din = b_in_vec[15-4*i -: 4];
            cyc();
        end
        check("quad_rx_valid", {31'h0, b_rx_valid}, 32'd1);
        check("quad_busy_done", {31'h0, b_busy}, 32'd0);
        cyc();

        // 4) Stall for 5 cycles after 6 beats, then hold rx_ready low for extra cycles
        w = 16'h3C5A;
        a_loop = 1; a_msb = 1; a_beats = 5'd16; a_ld_data = w; a_ld_valid = 1;
        a_shift_en = 1; a_rx_ready = 0;
        q_a.push_back(mk(w, 1'b0));
        cyc();
        a_ld_valid = 0;
        for (int k = 0; k < 6; k++) begin
            cyc();
        end
        a_shift_en = 0;
        for (int s = 0; s < 5; s++) begin
            cyc();
            check($sformatf("stall_dout%0d", s), {31'h0, a_dout}, {31'h0, w[9]});
            check($sformatf("stall_busy%0d", s), {31'h0, a_busy}, 32'd1);
        end
        a_shift_en = 1;
        for (int k = 6; k < 16; k++) begin
            check($sformatf("resume_dout%0d", k), {31'h0, a_dout}, {31'h0, w[15-k]});
            cyc();
        end
        for (int h = 0; h < 3; h++) begin
            check($sformatf("bp_valid%0d", h), {31'h0, a_rx_valid}, 32'd1);
            check($sformatf("bp_data%0d", h), {16'h0, a_rx_data}, {16'h0, w});
            check($sformatf("bp_ld_ready%0d", h), {31'h0, a_ld_ready}, 32'd0);
            cyc();
        end
        a_rx_ready = 1;
        cyc();
        check("bp_released", {31'h0, a_ld_ready}, 32'd1);

        // 5) Abort at beat 5 of 16, then a clean frame of 0x0001
        a_loop = 0; a_din_drv = 0; a_msb = 1; a_beats = 5'd16; a_ld_data = 16'hFFFF;
        a_ld_valid = 1; a_shift_en = 1;
        cyc();
        a_ld_valid = 0;
        for (int k = 0; k < 5; k++) begin
            cyc();
        end
        a_clr = 1;
        cyc();
        a_clr = 0;
        check("abort_ld_ready", {31'h0, a_ld_ready}, 32'd1);
        check("abort_busy", {31'h0, a_busy}, 32'd0);
        check("abort_rx_valid", {31'h0, a_rx_valid}, 32'd0);
        check("abort_dout", {31'h0, a_dout}, 32'd0);
        cyc();
        frame_a(16'h0001, 1'b1, "post_abort");

        // 6) Asynchronous reset after 3 beats, then a parity frame of 0x0007
        a_loop = 0; a_din_drv = 1; a_msb = 1; a_beats = 5'd16; a_ld_data = 16'h5555;
        a_ld_valid = 1; a_shift_en = 1;
        cyc();
        a_ld_valid = 0;
        for (int k = 0; k < 3; k++) begin
            cyc();
        end
        #1;
        reset_ni = 0;
        #1;
        check("arst_busy", {31'h0, a_busy}, 32'd0);
        check("arst_ld_ready", {31'h0, a_ld_ready}, 32'd1);
        check("arst_rx_valid", {31'h0, a_rx_valid}, 32'd0);
        check("arst_rx_data", {16'h0, a_rx_data}, 32'h0);
        check("arst_dout", {31'h0, a_dout}, 32'd0);
        check("arst_parity", {31'h0, a_rx_parity}, 32'd0);
        @(negedge clk);
        reset_ni = 1;
        cyc();
        frame_a(16'h0007, 1'b1, "parity");

        repeat (3) cyc();
        check("q_a_drained", q_a.size(), 32'd0);
        check("q_b_drained", q_b.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
